// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared constants for the multi-cycle RV32I control path: opcodes, branch
// funct3 codes, the ALUOP encoding (also consumed by alu_dec), datapath mux
// select encodings and the controller state enum.
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the StTrap state.
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    // Opcodes, instr[6:0]
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // Branch funct3, instr[14:12]
    localparam logic [2:0] F3Beq = 3'b000;
    localparam logic [2:0] F3Bne = 3'b001;
    localparam logic [2:0] F3Blt = 3'b100;

    // ALUOP to alu_dec
    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpFunct  = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // ResultSrc
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // ImmSrc
    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StBranch
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        StTrap
`endif
    } state_e;

endpackage

// File: rtl/imm_src_dec.sv
// ----------------------------------------------------------------------------
// imm_src_dec
// Combinational opcode -> immediate format select.
//   op_i      : instruction opcode, instr[6:0]
//   imm_src_o : 00 I, 01 S, 10 B, 11 J
// ----------------------------------------------------------------------------
module imm_src_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    always_comb begin
        imm_src_o = ImmI;
        case (op_i)
            OpStore:  imm_src_o = ImmS;
            OpBranch: imm_src_o = ImmB;
            OpJal:    imm_src_o = ImmJ;
            default:  imm_src_o = ImmI;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle main controller for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback over a shared ALU and a single memory port.
// Inputs : clk, rst_n (async active-low), op, funct3, zero, lt, mem_ready
// Outputs: mem_req, ALUOP, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
//          IRWrite, PCWrite, RegWrite, MemWrite, illegal
// Parameter USE_MEM_READY: 0 treats mem_ready as permanently high.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unknown opcode -> sticky TRAP).
// State-decoded outputs are registered from the next state so that reset
// clears them immediately; IRWrite, PCWrite and ImmSrc are combinational.
// ----------------------------------------------------------------------------
module mc_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic [1:0] ALUOP,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic       mem_req_q, mem_req_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [1:0] src_a_q, src_a_d;
    logic [1:0] src_b_q, src_b_d;
    logic [1:0] res_src_q, res_src_d;
    logic       adr_src_q, adr_src_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic       ready;
    logic       fetch_done;
    logic       branch_taken;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    // The first cycle after reset has mem_req low, so no fetch completes there.
    assign fetch_done = (state_q == StFetch) && mem_req_q && ready;

    always_comb begin
        case (funct3)
            F3Beq:   branch_taken = zero;
            F3Bne:   branch_taken = ~zero;
            F3Blt:   branch_taken = lt;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (fetch_done) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:         state_d = StTrap;
`else
                    default:         state_d = StFetch;
`endif
                endcase
            end
            StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJal:      state_d = StAluWb;
            StBranch:   state_d = StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
            StTrap:     state_d = StTrap;
`endif
            default:    state_d = StFetch;
        endcase
    end

    // Moore outputs of the state being entered, registered alongside it.
    always_comb begin
        mem_req_d   = 1'b0;
        alu_op_d    = AluOpAdd;
        src_a_d     = SrcAPc;
        src_b_d     = SrcBRd2;
        res_src_d   = ResAluOut;
        adr_src_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_write_d = 1'b0;
        case (state_d)
            StFetch: begin
                mem_req_d = 1'b1;
                src_b_d   = SrcBFour;
                res_src_d = ResAluResult;
            end
            StDecode: begin
                src_a_d = SrcAOldPc;
                src_b_d = SrcBImm;
            end
            StMemAdr: begin
                src_a_d = SrcARd1;
                src_b_d = SrcBImm;
            end
            StMemRead: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            StMemWb: begin
                res_src_d   = ResData;
                reg_write_d = 1'b1;
            end
            StMemWrite: begin
                mem_req_d   = 1'b1;
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            StExecR: begin
                src_a_d  = SrcARd1;
                alu_op_d = AluOpFunct;
            end
            StExecI: begin
                src_a_d  = SrcARd1;
                src_b_d  = SrcBImm;
                alu_op_d = AluOpFunct;
            end
            StAluWb:  reg_write_d = 1'b1;
            StJal: begin
                src_a_d = SrcAOldPc;
                src_b_d = SrcBFour;
            end
            StBranch: begin
                src_a_d  = SrcARd1;
                alu_op_d = AluOpBranch;
            end
            default: ;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d = illegal_q | (state_d == StTrap);
    assign illegal   = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            mem_req_q   <= 1'b0;
            alu_op_q    <= 2'b00;
            src_a_q     <= 2'b00;
            src_b_q     <= 2'b00;
            res_src_q   <= 2'b00;
            adr_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            alu_op_q    <= alu_op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            res_src_q   <= res_src_d;
            adr_src_q   <= adr_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign ALUOP     = alu_op_q;
    assign ALUSrcA   = src_a_q;
    assign ALUSrcB   = src_b_q;
    assign ResultSrc = res_src_q;
    assign AdrSrc    = adr_src_q;
    assign RegWrite  = reg_write_q;
    assign MemWrite  = mem_write_q;
    assign IRWrite   = fetch_done;
    assign PCWrite   = fetch_done || (state_q == StJal) ||
                       ((state_q == StBranch) && branch_taken);

    imm_src_dec u_imm_src_dec (
        .op_i      (op),
        .imm_src_o (ImmSrc)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Self-checking bench for mc_ctrl_fsm. Each cycle the expected output vector
// is pushed to a scoreboard queue as the inputs are driven, then popped and
// compared against the DUT on the falling edge.
// ----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam int SRst      = 0;
    localparam int SFetch    = 1;
    localparam int SDecode   = 2;
    localparam int SMemAdr   = 3;
    localparam int SMemRead  = 4;
    localparam int SMemWb    = 5;
    localparam int SMemWrite = 6;
    localparam int SExecR    = 7;
    localparam int SExecI    = 8;
    localparam int SAluWb    = 9;
    localparam int SJal      = 10;
    localparam int SBranch   = 11;
    localparam int STrap     = 12;

    typedef struct packed {
        logic       mem_req;
        logic [1:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [1:0] imm;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
    logic [1:0] ALUOP, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;

    out_t got;
    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .zero      (zero),
        .lt        (lt),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .ALUOP     (ALUOP),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .illegal   (illegal)
    );

    assign got = {mem_req, ALUOP, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                  AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got_v,
                            input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic out_t exp_out(input int st, input logic rdy,
                                     input logic pcw_br, input logic [6:0] o);
        out_t e;
        e     = '0;
        e.imm = imm_of(o);
        case (st)
            SFetch: begin
                e.mem_req = 1'b1; e.src_b = 2'b10; e.res = 2'b10;
                e.irw = rdy; e.pcw = rdy;
            end
            SDecode:   begin e.src_a = 2'b01; e.src_b = 2'b01; end
            SMemAdr:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
            SMemRead:  begin e.mem_req = 1'b1; e.adr = 1'b1; end
            SMemWb:    begin e.res = 2'b01; e.rw = 1'b1; end
            SMemWrite: begin e.mem_req = 1'b1; e.adr = 1'b1; e.mw = 1'b1; end
            SExecR:    begin e.src_a = 2'b10; e.alu_op = 2'b10; end
            SExecI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
            SAluWb:    e.rw = 1'b1;
            SJal:      begin e.src_a = 2'b01; e.src_b = 2'b10; e.pcw = 1'b1; end
            SBranch:   begin e.src_a = 2'b10; e.alu_op = 2'b01; e.pcw = pcw_br; end
            STrap:     e.ill = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive, push expectation, compare on the falling edge.
    task automatic step(input string name, input int st, input logic rdy,
                        input logic pcw_br);
        out_t e;
        mem_ready = rdy;
        exp_q.push_back(exp_out(st, rdy, pcw_br, op));
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq($sformatf("%s_c%0d", name, cyc_n + 1), {15'd0, got}, {15'd0, e});
        check_eq($sformatf("%s_mutex_c%0d", name, cyc_n + 1),
                 32'(($countones({got.rw, got.mw, got.irw}) <= 1)), 32'd1);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic z, input logic l, input int fstall,
                             input int mstall, input int exp_cyc);
        logic tk;
        op = o; funct3 = f3; zero = z; lt = l;
        cyc_n = 0;
        case (f3)
            3'b000:  tk = z;
            3'b001:  tk = ~z;
            3'b100:  tk = l;
            default: tk = 1'b0;
        endcase
        for (int i = 0; i < fstall; i++) step(name, SFetch, 1'b0, 1'b0);
        step(name, SFetch, 1'b1, 1'b0);
        step(name, SDecode, 1'b1, 1'b0);
        case (o)
            7'b0000011: begin
                step(name, SMemAdr, 1'b1, 1'b0);
                for (int i = 0; i < mstall; i++) step(name, SMemRead, 1'b0, 1'b0);
                step(name, SMemRead, 1'b1, 1'b0);
                step(name, SMemWb, 1'b1, 1'b0);
            end
            7'b0100011: begin
                step(name, SMemAdr, 1'b1, 1'b0);
                for (int i = 0; i < mstall; i++) step(name, SMemWrite, 1'b0, 1'b0);
                step(name, SMemWrite, 1'b1, 1'b0);
            end
            7'b0110011: begin
                step(name, SExecR, 1'b1, 1'b0);
                step(name, SAluWb, 1'b1, 1'b0);
            end
            7'b0010011: begin
                step(name, SExecI, 1'b1, 1'b0);
                step(name, SAluWb, 1'b1, 1'b0);
            end
            7'b1100011: step(name, SBranch, 1'b1, tk);
            7'b1101111: begin
                step(name, SJal, 1'b1, 1'b0);
                step(name, SAluWb, 1'b1, 1'b0);
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) step(name, STrap, 1'b1, 1'b0);
`endif
            end
        endcase
        check_eq({name, "_cycles"}, 32'(cyc_n), 32'(exp_cyc));
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000;
        zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        #2;
        check_eq("reset", {15'd0, got}, {15'd0, exp_out(SRst, 1'b0, 1'b0, op)});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset", SRst, 1'b1, 1'b0);

        run_instr("add",    7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 8);
        run_instr("beq_t",  7'b1100011, 3'b000, 1'b1, 1'b0, 0, 0, 3);
        run_instr("beq_n",  7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);
        run_instr("bne_t",  7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3);
        run_instr("blt_t",  7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 3);
        run_instr("f3_010", 7'b1100011, 3'b010, 1'b1, 1'b1, 0, 0, 3);
        run_instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 6);
        run_instr("addi",   7'b0010011, 3'b000, 1'b0, 1'b0, 2, 0, 6);
        run_instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);

        // Store stalled in MEMWRITE, then reset lands between clock edges.
        op = 7'b0100011; funct3 = 3'b010; cyc_n = 0;
        step("sw_rst", SFetch, 1'b1, 1'b0);
        step("sw_rst", SDecode, 1'b1, 1'b0);
        step("sw_rst", SMemAdr, 1'b1, 1'b0);
        step("sw_rst", SMemWrite, 1'b0, 1'b0);
        check_eq("sw_rst_pre", {30'd0, mem_req, MemWrite}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("sw_rst_drop", {30'd0, mem_req, MemWrite}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op = 7'b0110011;
        cyc_n = 0;
        step("rst_resume", SRst, 1'b1, 1'b0);
        run_instr("add2", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);

`ifdef MC_ILLEGAL_TRAP_EN
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 5);
`else
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 2);
        run_instr("add3",    7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
